// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions for the fetch front end: widths, FSM encoding and the
// {pc,instr} entry carried through the fetch queue.
package fetch_ctrl_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [WORD_W-1:0] HALT_WORD_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_ent_t;

    localparam int ENT_W = $bits(fetch_ent_t);

    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue holding fetched {pc,instr} entries; flush empties it
// in one edge and takes priority over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [CW-1:0]               cnt;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through a combinational
// instruction memory, queues {pc,instr} for decode, stops on HALT_WORD.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              redir;
    logic              pop_req;
    logic              push_req;
    logic              is_halt;
    logic              fifo_empty;
    logic              fifo_full;
    fetch_ent_t        push_ent;
    fetch_ent_t        head_ent;

    // Redirects only matter once fetch has been started.
    assign redir    = redirect_valid && (state != ST_IDLE);
    assign pop_req  = instr_valid && instr_ready && !redir;
    assign push_req = fetch_en && !redir && (!fifo_full || pop_req);
    assign is_halt  = (imem_data == HALT_WORD);

    assign push_ent    = '{pc: pc, instr: imem_data};
    assign imem_addr   = pc;
    assign instr_valid = !fifo_empty;
    assign instr       = head_ent.instr;
    assign instr_pc    = head_ent.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (redir)
                    state_nxt = ST_FETCH;
                else if (push_req && is_halt)
                    state_nxt = ST_HALTED;
            end
            ST_HALTED: if (redir) state_nxt = ST_FETCH;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_en = 1'b0;
        halted   = 1'b0;
        unique case (state)
            ST_FETCH:  fetch_en = 1'b1;
            ST_HALTED: halted   = 1'b1;
            default: ;
        endcase
    end

    // A halt word is queued but the PC stays parked on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (redir)
            pc <= redirect_addr;
        else if (push_req && !is_halt)
            pc <= pc_next(pc);
    end

    fetch_fifo #(
        .DEPTH (2),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redir),
        .push      (push_req),
        .push_data (push_ent),
        .pop       (pop_req),
        .head      (head_ent),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_fetch_ctrl;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] HALT   = 16'hFFFF;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] w;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        halted;

    logic [15:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC), .HALT_WORD(HALT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: started/halted flags, a PC and a queue of at most two entries.
    ent_t        mq[$];
    logic [15:0] mpc = RST_PC;
    bit          m_run = 0;
    bit          m_halt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc    = RST_PC;
            m_run  = 0;
            m_halt = 0;
        end else if (!m_run && !m_halt) begin
            if (start) m_run = 1;
        end else if (redirect_valid) begin
            mq.delete();
            mpc    = redirect_addr;
            m_run  = 1;
            m_halt = 0;
        end else begin
            if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
            if (m_run && mq.size() < 2) begin
                mq.push_back('{pc: mpc, w: mem[mpc]});
                if (mem[mpc] == HALT) begin
                    m_run  = 0;
                    m_halt = 1;
                end else begin
                    mpc = mpc + 16'd1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("imem_addr", {16'd0, imem_addr}, {16'd0, mpc});
        if (mq.size() > 0) begin
            chk("instr_pc", {16'd0, instr_pc}, {16'd0, mq[0].pc});
            chk("instr", {16'd0, instr}, {16'd0, mq[0].w});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input bit v, input logic [15:0] pc);
        chk({nm, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
        if (v) chk({nm, "_pc"}, {16'd0, instr_pc}, {16'd0, pc});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) step();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_addr", {16'd0, imem_addr}, {16'd0, RST_PC});
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_ipc", {16'd0, instr_pc}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            mem[a] = (w == HALT) ? 16'h1234 : w;
        end
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = HALT;
        mem[16'hFFFF] = 16'h7777;

        // Straight run into a halt word.
        do_reset();
        start = 1'b1; instr_ready = 1'b1;
        step(); lit("c1_e1", 0, 0);
        step(); lit("c1_p0", 1, 16'h0000); chk("c1_w0", {16'd0, instr}, 32'h1111);
        step(); lit("c1_p1", 1, 16'h0001); chk("c1_w1", {16'd0, instr}, 32'h2222);
        step(); lit("c1_p2", 1, 16'h0002); chk("c1_w2", {16'd0, instr}, 32'h3333);
        step(); lit("c1_p3", 1, 16'h0003); chk("c1_h3", {31'd0, halted}, 32'd1);
        step(); lit("c1_end", 0, 0); chk("c1_hend", {31'd0, halted}, 32'd1);
        step(); lit("c1_idle", 0, 0);

        // Back-pressure: queue fills with pc 0,1 and stalls at addr 2.
        do_reset();
        start = 1'b1; instr_ready = 1'b0;
        repeat (4) step();
        lit("c2_hold", 1, 16'h0000);
        chk("c2_addr", {16'd0, imem_addr}, 32'h0002);
        chk("c2_w0", {16'd0, instr}, 32'h1111);
        instr_ready = 1'b1;
        step(); lit("c2_p1", 1, 16'h0001);
        step(); lit("c2_p2", 1, 16'h0002);

        // Redirect into a full queue while decode is ready.
        do_reset();
        start = 1'b1; instr_ready = 1'b0;
        repeat (3) step();
        lit("c3_full", 1, 16'h0000);
        redirect_valid = 1'b1; redirect_addr = 16'h0040; instr_ready = 1'b1;
        step(); lit("c3_flush", 0, 0); chk("c3_addr", {16'd0, imem_addr}, 32'h0040);
        redirect_valid = 1'b0;
        step(); lit("c3_tgt", 1, 16'h0040);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
        step(); chk("c4_addr", {16'd0, imem_addr}, 32'hFFFF);
        redirect_valid = 1'b0;
        step(); lit("c4_top", 1, 16'hFFFF);
        step(); lit("c4_wrap", 1, 16'h0000);

        // Leave HALTED through a redirect.
        redirect_valid = 1'b1; redirect_addr = 16'h0003;
        step(); redirect_valid = 1'b0;
        step(); lit("c5_halt", 1, 16'h0003); chk("c5_h1", {31'd0, halted}, 32'd1);
        step(); lit("c5_drain", 0, 0);
        redirect_valid = 1'b1; redirect_addr = 16'h0010;
        step(); chk("c5_h0", {31'd0, halted}, 32'd0); chk("c5_addr", {16'd0, imem_addr}, 32'h0010);
        redirect_valid = 1'b0;
        step(); lit("c5_res", 1, 16'h0010);

        // Asynchronous reset mid-stream.
        repeat (3) step();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("c6_valid", {31'd0, instr_valid}, 32'd0);
        chk("c6_addr", {16'd0, imem_addr}, {16'd0, RST_PC});
        chk("c6_halted", {31'd0, halted}, 32'd0);
        step(); start = 1'b0;
        step(); rst_n = 1'b1;
        repeat (3) step();
        lit("c6_idle", 0, 0); chk("c6_addr2", {16'd0, imem_addr}, {16'd0, RST_PC});
        start = 1'b1;
        step(); step(); lit("c6_res", 1, 16'h0000);

        // Randomized traffic with halt words sprinkled in the low region.
        for (int a = 4; a < 512; a++)
            if ($urandom_range(0, 19) == 0) mem[a] = HALT;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            start          = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                         : 16'($urandom_range(0, 511));
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
